period_capture: RTL



---
 rtl/periph_cap_pkg.sv | 13 +
 rtl/sync_edge.sv | 33 +++
 rtl/period_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/periph_cap_pkg.sv
// Shared types and default sizing for the input-capture timer channels.
package periph_cap_pkg;

    localparam int CAP_WIDTH       = 32;
    localparam int CAP_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus single-cycle
// rise/fall pulses taken against a registered copy of the synchronized level.
module sync_edge
    import periph_cap_pkg::*;
#(
    parameter int SYNC_STAGES = CAP_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~last_q;
    assign fall  = ~level & last_q;

endmodule

// File: rtl/period_capture.sv
// Input-capture timer: period (rise to rise) and high time of sig_in in clk cycles,
// delivered over valid/ready. High-time logic is built only when PERIOD_CAPTURE_HIGH_EN is defined.
module period_capture
    import periph_cap_pkg::*;
#(
    parameter int WIDTH       = CAP_WIDTH,
    parameter int SYNC_STAGES = CAP_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    output logic             lost
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    cap_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cap_high;
    logic             level, rise, fall;
    logic             measuring, capture, ovf_hit;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (sig_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign measuring = en && (state == MEASURE);
    assign capture   = measuring && rise;
    // Reaching the top count without a rise means the true period cannot be represented.
    assign ovf_hit   = measuring && !rise && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: state <= ARM;
                ARM: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        state <= ARM;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERIOD_CAPTURE_HIGH_EN
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] hi_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            hi_lat <= '0;
        end else if (!en) begin
            hcnt <= '0;
        end else if (state == ARM && rise) begin
            hcnt <= CNT_ONE;
        end else if (state == MEASURE) begin
            if (rise) begin
                hcnt <= CNT_ONE;
            end else if (level) begin
                hcnt <= sat_inc(hcnt);
            end
            if (fall) begin
                hi_lat <= hcnt;
            end
        end
    end

    assign cap_high = hi_lat;
`else
    logic unused_high;
    assign unused_high = level | fall;
    assign cap_high    = '0;
`endif

    // A capture always wins over a same-cycle handshake; lost only records a capture landing on an unread result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            lost      <= 1'b0;
        end else if (capture) begin
            period    <= cnt;
            high_time <= cap_high;
            valid     <= 1'b1;
            overflow  <= 1'b0;
            if (valid && !ready) begin
                lost <= 1'b1;
            end
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
                lost  <= 1'b0;
            end
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
